// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer master bridge.
// Converts a level-held CPU memory request into exactly one Wishbone cycle and
// holds the pipeline with stall_o until the slave terminates the cycle.
// Read data is buffered while the pipeline is held by another requester.
//
// Handshake: the CPU raises cpu_ce_i and keeps the request fields stable until
// it samples stall_o low at a rising edge, which is the edge that consumes the request.
// On the bus, a transfer is a cycle with cyc=stb=1 that is terminated by ack,
// err, or the internal timeout.
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stall_o,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic [1:0]          dbg_state_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                err_q, err_d;

  logic                timeout_hit;
  logic                bus_err;
  logic                term;
  logic                flushed;
  logic                stall_c;
  logic [DATA_W-1:0]   cpu_data_c;

  // Termination sources; an ack that coincides with err is treated as an error.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    bus_err     = wb_err_i | timeout_hit;
    term        = wb_ack_i | bus_err;
    flushed     = flush_q | flush_i;
  end

  // Next-state and output logic for the IDLE/BUSY/HOLD transfer sequencer.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    err_d      = 1'b0;
    stall_c    = 1'b0;
    cpu_data_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          we_d    = cpu_we_i;
          adr_d   = cpu_addr_i;
          sel_d   = cpu_sel_i;
          dat_d   = cpu_data_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          flush_d = 1'b0;
          stall_c = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!term) begin
          cnt_d   = cnt_q + CNT_W'(1);
          stall_c = 1'b1;
          if (flush_i) flush_d = 1'b1;
        end else begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          // A flushed or failed transfer leaves nothing usable in the buffer.
          buf_d      = (bus_err || flushed) ? '0 : wb_dat_i;
          err_d      = bus_err & ~flushed;
          stall_c    = flush_i;
          cpu_data_c = wb_dat_i;
          flush_d    = 1'b0;
          state_d    = (stall_i && !flushed) ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        cpu_data_c = buf_q;
        if (!stall_i || flush_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus-output registers, cleared asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Output drive; stall is masked while reset is asserted so the pipeline is released at once.
  always_comb begin
    stall_o     = stall_c & wb_rst_i;
    cpu_data_o  = cpu_data_c;
    err_o       = err_q;
    wb_cyc_o    = cyc_q;
    wb_stb_o    = stb_q;
    wb_we_o     = we_q;
    wb_adr_o    = adr_q;
    wb_sel_o    = sel_q;
    wb_dat_o    = dat_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Testbench for wb_master_bridge: directed transfers with a bus-side scoreboard.
module tb_wb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam int RW = 1 + AW + SW + DW + DW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          err;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_ce, cpu_we, stall_i, flush_i;
  logic [AW-1:0] cpu_addr;
  logic [SW-1:0] cpu_sel;
  logic [DW-1:0] cpu_wdat, cpu_rdat;
  logic          stall_o, err_o;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [AW-1:0] wb_adr;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [1:0]    dbg_state;

  wb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .cpu_ce_i   (cpu_ce),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_sel_i  (cpu_sel),
    .cpu_data_i (cpu_wdat),
    .cpu_data_o (cpu_rdat),
    .stall_o    (stall_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .err_o      (err_o),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (wb_adr),
    .wb_sel_o   (wb_sel),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_ce = 0; cpu_we = 0; cpu_addr = '0; cpu_sel = '0; cpu_wdat = '0;
    wb_ack = 0; wb_err = 0; wb_dat_i = '0; flush_i = 0; stall_i = 0;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Raise a CPU request and record what the bus must show at termination.
  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
    txn_t t;
    cpu_ce = 1; cpu_we = we; cpu_addr = adr; cpu_sel = sel; cpu_wdat = wd;
    t = '{we: we, adr: adr, sel: sel, wd: wd, rd: rd, err: err};
    exp_q.push_back(RW'(t));
  endtask

  // ---------------- monitor ----------------
  // When cyc falls, the previous sample was the terminating cycle; err_o is visible now.
  logic prev_cyc = 1'b0;
  txn_t snap;
  txn_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc = 1'b0;
    end else begin
      if (prev_cyc && !wb_cyc) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_txn actual=adr 0x%0h required=none", snap.adr);
        end else begin
          mon_e = txn_t'(exp_q.pop_front());
          chk("mon_we",  64'(snap.we),  64'(mon_e.we));
          chk("mon_adr", 64'(snap.adr), 64'(mon_e.adr));
          chk("mon_sel", 64'(snap.sel), 64'(mon_e.sel));
          chk("mon_wd",  64'(snap.wd),  64'(mon_e.wd));
          chk("mon_rd",  64'(snap.rd),  64'(mon_e.rd));
          chk("mon_err", 64'(err_o),    64'(mon_e.err));
        end
      end
      snap     = '{we: wb_we, adr: wb_adr, sel: wb_sel, wd: wb_dat_o, rd: cpu_rdat, err: 1'b0};
      prev_cyc = wb_cyc;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 0;
    drive_idle();
    cpu_ce = 1;
    repeat (2) to_neg();
    chk("rst_cyc",   64'(wb_cyc),    0);
    chk("rst_stb",   64'(wb_stb),    0);
    chk("rst_we",    64'(wb_we),     0);
    chk("rst_adr",   64'(wb_adr),    0);
    chk("rst_sel",   64'(wb_sel),    0);
    chk("rst_dat",   64'(wb_dat_o),  0);
    chk("rst_err",   64'(err_o),     0);
    chk("rst_stall", 64'(stall_o),   0);
    chk("rst_data",  64'(cpu_rdat),  0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    cpu_ce = 0;
    #2 rst_n = 1;
    to_drive();

    // Read with zero-wait ack.
    issue(0, 32'h40, 4'hF, 32'h1111_1111, 32'h1234_5678, 0);
    to_neg();
    chk("t1_stall_req", 64'(stall_o), 1);
    chk("t1_cyc_req",   64'(wb_cyc),  0);
    to_drive();
    wb_ack = 1; wb_dat_i = 32'h1234_5678;
    to_neg();
    chk("t1_cyc_ack",   64'(wb_cyc),   1);
    chk("t1_stall_ack", 64'(stall_o),  0);
    chk("t1_data_ack",  64'(cpu_rdat), 64'h1234_5678);
    to_drive();
    drive_idle();
    to_neg();
    chk("t1_cyc_after",  64'(wb_cyc),    0);
    chk("t1_data_idle",  64'(cpu_rdat),  0);
    chk("t1_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Write with three wait states.
    to_drive();
    issue(1, 32'h100, 4'b0011, 32'hA5A5_0F0F, 32'h0, 0);
    to_neg();
    chk("t2_stall_req", 64'(stall_o), 1);
    for (int i = 0; i < 4; i++) begin
      to_drive();
      wb_ack = (i == 3);
      to_neg();
      chk("t2_adr",   64'(wb_adr),   64'h100);
      chk("t2_dat",   64'(wb_dat_o), 64'hA5A5_0F0F);
      chk("t2_sel",   64'(wb_sel),   64'h3);
      chk("t2_we",    64'(wb_we),    1);
      chk("t2_cyc",   64'(wb_cyc),   1);
      chk("t2_stall", 64'(stall_o),  (i == 3) ? 0 : 1);
    end
    to_drive();
    drive_idle();
    to_neg();
    chk("t2_cyc_after",   64'(wb_cyc),  0);
    chk("t2_stall_after", 64'(stall_o), 0);

    // Ack while the pipeline is held elsewhere: data parked in HOLD.
    to_drive();
    issue(0, 32'h80, 4'hF, 32'h0, 32'hCAFE_F00D, 0);
    to_neg();
    to_drive();
    wb_ack = 1; wb_dat_i = 32'hCAFE_F00D; stall_i = 1;
    to_neg();
    chk("t3_stall_ack", 64'(stall_o),  0);
    chk("t3_data_ack",  64'(cpu_rdat), 64'hCAFE_F00D);
    to_drive();
    wb_ack = 0; wb_dat_i = '0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t3_hold_data",  64'(cpu_rdat),  64'hCAFE_F00D);
      chk("t3_hold_cyc",   64'(wb_cyc),    0);
      chk("t3_hold_stall", 64'(stall_o),   0);
      chk("t3_hold_state", 64'(dbg_state), 64'(ST_HOLD));
      to_drive();
    end
    stall_i = 0; cpu_ce = 0;
    to_neg();
    chk("t3_release_data", 64'(cpu_rdat), 64'hCAFE_F00D);
    to_drive();
    to_neg();
    chk("t3_idle_data",  64'(cpu_rdat),  0);
    chk("t3_idle_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("t3_idle_cyc",   64'(wb_cyc),    0);

    // Timeout with no slave response.
    to_drive();
    issue(0, 32'h200, 4'hF, 32'h0, 32'h0, 1);
    to_neg();
    for (int i = 0; i < 5; i++) begin
      to_drive();
      to_neg();
      chk("t4_cyc",   64'(wb_cyc),  1);
      chk("t4_stall", 64'(stall_o), (i == 4) ? 0 : 1);
    end
    chk("t4_data_term", 64'(cpu_rdat), 0);
    to_drive();
    cpu_ce = 0;
    to_neg();
    chk("t4_cyc_after", 64'(wb_cyc), 0);
    chk("t4_err_pulse", 64'(err_o),  1);
    to_drive();
    to_neg();
    chk("t4_err_clear", 64'(err_o), 0);

    // Ack and err together count as an error; buffered data is zero.
    to_drive();
    issue(0, 32'h300, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
    to_neg();
    to_drive();
    wb_ack = 1; wb_err = 1; wb_dat_i = 32'hDEAD_BEEF; stall_i = 1;
    to_neg();
    chk("t5_stall_term", 64'(stall_o), 0);
    to_drive();
    wb_ack = 0; wb_err = 0; wb_dat_i = '0; cpu_ce = 0;
    to_neg();
    chk("t5_state_hold", 64'(dbg_state), 64'(ST_HOLD));
    chk("t5_buf_zero",   64'(cpu_rdat),  0);
    chk("t5_err_pulse",  64'(err_o),     1);
    to_drive();
    stall_i = 0;
    to_neg();
    chk("t5_err_clear", 64'(err_o), 0);
    to_drive();
    to_neg();
    chk("t5_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Flush mid-cycle: cycle completes, result dropped, IDLE despite stall_i.
    to_drive();
    issue(0, 32'h400, 4'hF, 32'h0, 32'h5555_AAAA, 0);
    to_neg();
    to_drive();
    to_neg();
    chk("t6_stall_b1", 64'(stall_o), 1);
    to_drive();
    flush_i = 1; cpu_ce = 0;
    to_neg();
    chk("t6_stall_b2", 64'(stall_o), 1);
    chk("t6_cyc_b2",   64'(wb_cyc),  1);
    to_drive();
    flush_i = 0; wb_ack = 1; wb_dat_i = 32'h5555_AAAA; stall_i = 1;
    to_neg();
    chk("t6_stall_ack", 64'(stall_o), 0);
    chk("t6_cyc_ack",   64'(wb_cyc),  1);
    to_drive();
    wb_ack = 0; wb_dat_i = '0;
    to_neg();
    chk("t6_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("t6_no_err",     64'(err_o),     0);
    chk("t6_cyc_after",  64'(wb_cyc),    0);
    to_drive();
    stall_i = 0;

    // Asynchronous reset in the middle of a bus cycle.
    cpu_ce = 1; cpu_addr = 32'h500; cpu_sel = 4'hF;
    to_neg();
    to_drive();
    to_neg();
    chk("t7_cyc_busy",   64'(wb_cyc),  1);
    chk("t7_stall_busy", 64'(stall_o), 1);
    #2 rst_n = 0;
    #1;
    chk("t7_cyc_rst",   64'(wb_cyc),  0);
    chk("t7_stb_rst",   64'(wb_stb),  0);
    chk("t7_stall_rst", 64'(stall_o), 0);
    to_neg();
    #2;
    drive_idle();
    rst_n = 1;
    to_drive();
    to_neg();
    chk("t7_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("t7_cyc_idle",   64'(wb_cyc),    0);

    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
